// File: rtl/hdd_pkg.sv
// rtl/hdd_pkg.sv - shared state type and constants for the HDD/SD bridge
package hdd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_FIN
  } hdd_state_t;

  localparam int SECTOR_BYTES = 512;

  // ProDOS status codes kept here for the status register that will report them
  localparam logic [7:0] NO_DEVICE = 8'h28;
  localparam logic [7:0] PROTECT   = 8'h2B;

endpackage

// File: rtl/hdd_ack_timer.sv
// rtl/hdd_ack_timer.sv - saturating ack-wait counter
module hdd_ack_timer #(
  parameter int TIMEOUT_W = 24
) (
  input  logic CLK_14M,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

  logic [TIMEOUT_W-1:0] cnt;

  // count enabled cycles, holding at the maximum
  always_ff @(posedge CLK_14M) begin
    if (RESET || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // fires on the enabled cycle that completes 2^TIMEOUT_W-1 cycles of waiting
  assign expired = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/hdd_sd_bridge.sv
// rtl/hdd_sd_bridge.sv - HDD single-sector strobes to block-device host port
module hdd_sd_bridge
  import hdd_pkg::*;
#(
  parameter logic [31:0] LBA_OFFSET = 32'd0,
  parameter int          TIMEOUT_W  = 24
) (
  input  logic        CLK_14M,
  input  logic        RESET,
  input  logic        hdd_read,
  input  logic        hdd_write,
  input  logic [15:0] sector,
  input  logic        hdd_mounted,
  input  logic        hdd_protect,
  output logic [8:0]  ram_addr,
  output logic [7:0]  ram_di,
  output logic        ram_we,
  input  logic [7:0]  ram_do,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        busy,
  output logic        done,
  output logic        err
);

  hdd_state_t  state, state_n;
  logic        rd_q, wr_q;
  logic        rd_edge, wr_edge;
  logic [15:0] sector_q;
  logic        ack_q, ack_fall;
  logic        dir_rd, req_rd;
  logic        accept, refuse;
  logic [9:0]  byte_cnt;
  logic        tmo, tmo_fire, short_rd;

  hdd_ack_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
    .CLK_14M (CLK_14M),
    .RESET   (RESET),
    .clear   (state != ST_REQ),
    .enable  (state == ST_REQ),
    .expired (tmo)
  );

  assign ack_fall = ack_q && !sd_ack;
  assign tmo_fire = (state == ST_REQ) && !sd_ack && tmo;
  assign short_rd = (state == ST_XFER) && ack_fall && dir_rd && (byte_cnt != 10'(SECTOR_BYTES));

  // register request levels into one-cycle edge strobes; capture sector on the edge
  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rd_edge  <= 1'b0;
      wr_edge  <= 1'b0;
      sector_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      rd_q    <= hdd_read;
      wr_q    <= hdd_write;
      rd_edge <= hdd_read && !rd_q;
      wr_edge <= hdd_write && !wr_q;
      if ((hdd_read && !rd_q) || (hdd_write && !wr_q)) begin
        sector_q <= sector;
      end
      ack_q <= sd_ack;
    end
  end

  // state register
  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next state, request acceptance and the DMA/host steering
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    refuse      = 1'b0;
    req_rd      = dir_rd;
    busy        = (state != ST_IDLE);
    sd_rd       = 1'b0;
    sd_wr       = 1'b0;
    ram_addr    = '0;
    ram_di      = '0;
    ram_we      = 1'b0;
    sd_buff_din = '0;
    case (state)
      ST_IDLE: begin
        if (rd_edge) begin
          req_rd = 1'b1;
          accept = hdd_mounted;
          refuse = !hdd_mounted;
        end else if (wr_edge) begin
          req_rd = 1'b0;
          accept = hdd_mounted && !hdd_protect;
          refuse = !(hdd_mounted && !hdd_protect);
        end
        if (accept) begin
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        sd_rd = dir_rd;
        sd_wr = !dir_rd;
        if (sd_ack) begin
          state_n = ST_XFER;
        end else if (tmo) begin
          state_n = ST_FIN;
        end
      end
      ST_XFER: begin
        ram_addr = sd_buff_addr;
        if (dir_rd) begin
          ram_di = sd_buff_dout;
          ram_we = sd_buff_wr && sd_ack;
        end else begin
          sd_buff_din = ram_do;
        end
        if (ack_fall) begin
          state_n = ST_FIN;
        end
      end
      ST_FIN: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // latch the block address and direction, count bytes, track done/err
  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      dir_rd   <= 1'b0;
      sd_lba   <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      byte_cnt <= '0;
    end else begin
      done <= refuse || (state == ST_FIN);
      if (accept) begin
        dir_rd <= req_rd;
        sd_lba <= LBA_OFFSET + {16'h0000, sector_q};
        err    <= 1'b0;
      end
      if (refuse || tmo_fire || short_rd) begin
        err <= 1'b1;
      end
      if (state == ST_FIN) begin
        byte_cnt <= '0;
      end else if (ram_we) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

endmodule
